// File: rtl/find_peak.sv
// Streaming peak finder: reduces a window of WIN_LEN valid-qualified unsigned
// samples to its maximum and the earliest index at which that maximum occurred.
module find_peak #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned WIN_LEN = 64,
  parameter int unsigned IDX_W   = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             busy,
  output logic [WIDTH-1:0] peak,
  output logic [IDX_W-1:0] peak_idx,
  output logic             peak_valid,
  output logic             overrun
);

  typedef enum logic {
    IDLE = 1'b0,
    ACQ  = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN_LEN - 1);

  state_t           state;
  state_t           next_state;
  logic [IDX_W-1:0] cnt;
  logic [WIDTH-1:0] run_max;
  logic [IDX_W-1:0] run_idx;
  logic [WIDTH-1:0] cand_max;
  logic [IDX_W-1:0] cand_idx;
  logic             accept;
  logic             last;
  logic             busy_d;
  logic             peak_valid_d;
  logic             overrun_d;

  assign accept = (state == ACQ) && din_valid;
  assign last   = (cnt == LAST_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = ACQ;
      ACQ:     if (accept && last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy_d       = (next_state == ACQ);
    peak_valid_d = accept && last;
    overrun_d    = (state == ACQ) && start;
  end

  // Strict greater-than keeps the earliest index on ties; index 0 always loads.
  always_comb begin
    cand_max = run_max;
    cand_idx = run_idx;
    if ((cnt == '0) || (din > run_max)) begin
      cand_max = din;
      cand_idx = cnt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      run_max <= '0;
      run_idx <= '0;
    end else if ((state == IDLE) && start) begin
      cnt <= '0;
    end else if (accept) begin
      run_max <= cand_max;
      run_idx <= cand_idx;
      cnt     <= last ? '0 : cnt + IDX_W'(1);
    end
  end

  // The final result includes the last sample, so it is taken from the
  // candidate rather than from the running registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy       <= 1'b0;
      peak       <= '0;
      peak_idx   <= '0;
      peak_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      busy       <= busy_d;
      peak_valid <= peak_valid_d;
      overrun    <= overrun_d;
      if (peak_valid_d) begin
        peak     <= cand_max;
        peak_idx <= cand_idx;
      end
    end
  end

endmodule

// File: tb/tb_find_peak.sv
// Directed bench for find_peak: a queue-based window model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_find_peak;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned WIN_LEN = 64;
  localparam int unsigned IDX_W   = 6;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             din_valid = 1'b0;
  logic             busy;
  logic [WIDTH-1:0] peak;
  logic [IDX_W-1:0] peak_idx;
  logic             peak_valid;
  logic             overrun;

  int total = 0;
  int bad   = 0;

  find_peak #(.WIDTH(WIDTH), .WIN_LEN(WIN_LEN), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .din       (din),
    .din_valid (din_valid),
    .busy      (busy),
    .peak      (peak),
    .peak_idx  (peak_idx),
    .peak_valid(peak_valid),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Behavioural model: a window is a list of accepted samples; its result is
  // the first position holding the largest value.
  bit         m_open  = 1'b0;
  int         m_q[$];
  int         m_peak  = 0;
  int         m_idx   = 0;
  bit         m_pv    = 1'b0;
  bit         m_ovr   = 1'b0;
  int         pv_count  = 0;
  int         ovr_count = 0;
  int         cyc       = 0;
  int         pv_cyc    = -1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_open = 1'b0;
      m_q.delete();
      m_peak = 0;
      m_idx  = 0;
      m_pv   = 1'b0;
      m_ovr  = 1'b0;
    end else begin
      cyc   = cyc + 1;
      m_pv  = 1'b0;
      m_ovr = 1'b0;
      if (!m_open) begin
        if (start) begin
          m_open = 1'b1;
          m_q.delete();
        end
      end else begin
        if (start) m_ovr = 1'b1;
        if (din_valid) begin
          m_q.push_back(int'(din));
          if (m_q.size() == WIN_LEN) begin
            m_peak = m_q[0];
            m_idx  = 0;
            for (int k = 1; k < m_q.size(); k++) begin
              if (m_q[k] > m_peak) begin
                m_peak = m_q[k];
                m_idx  = k;
              end
            end
            m_pv   = 1'b1;
            m_open = 1'b0;
            pv_cyc = cyc;
          end
        end
      end
      if (m_pv)  pv_count  = pv_count + 1;
      if (m_ovr) ovr_count = ovr_count + 1;
    end
  end

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      total = total + 1;
      if (busy !== m_open || peak_valid !== m_pv || overrun !== m_ovr ||
          peak !== WIDTH'(m_peak) || peak_idx !== IDX_W'(m_idx)) begin
        bad = bad + 1;
        $display("FAIL cycle_model t=%0t: busy=%b pv=%b ovr=%b peak=%h idx=%0d required busy=%b pv=%b ovr=%b peak=%h idx=%0d",
                 $time, busy, peak_valid, overrun, peak, peak_idx,
                 m_open, m_pv, m_ovr, WIDTH'(m_peak), m_idx);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic open_window();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [WIDTH-1:0] v);
    din       = v;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  int start_cyc;
  int pv_before;
  int ovr_before;

  initial begin
    // Reset state
    #12;
    reset = 1'b0;
    #1;
    cmp_en = 1'b1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_peak", int'(peak), 0);
    chk("reset_idx", int'(peak_idx), 0);
    chk("reset_pv", int'(peak_valid), 0);
    tick();

    // Ramp 0..63
    open_window();
    start_cyc = cyc;
    chk("ramp_busy_after_start", int'(busy), 1);
    for (int i = 0; i < 64; i++) send(WIDTH'(i));
    chk("ramp_pv", int'(peak_valid), 1);
    chk("ramp_peak", int'(peak), 63);
    chk("ramp_idx", int'(peak_idx), 63);
    chk("ramp_busy_done", int'(busy), 0);
    chk("ramp_latency", pv_cyc - start_cyc, 64);
    tick();
    chk("ramp_pv_single", int'(peak_valid), 0);
    chk("ramp_pv_count", pv_count, 1);

    // Tie: earliest index wins
    open_window();
    for (int i = 0; i < 64; i++) send((i == 5 || i == 40) ? 16'h8000 : 16'h0100);
    chk("tie_peak", int'(peak), 'h8000);
    chk("tie_idx", int'(peak_idx), 5);
    tick();

    // Gapped input, sample in the start cycle ignored
    din = 16'hFFFF;
    din_valid = 1'b1;
    open_window();
    for (int i = 0; i < 64; i++) begin
      send((i == 0) ? 16'hFFFF : WIDTH'(i * 3));
      din = 16'hFFFF;
      if (i != 63) tick();
    end
    chk("gap_pv", int'(peak_valid), 1);
    chk("gap_peak", int'(peak), 'hFFFF);
    chk("gap_idx", int'(peak_idx), 0);
    tick();

    // Overrun mid-window, then back-to-back
    ovr_before = ovr_count;
    open_window();
    for (int i = 0; i < 64; i++) begin
      if (i == 10) start = 1'b1;
      send(WIDTH'(200 - ((i > 20) ? (i - 20) : (20 - i))));
      start = 1'b0;
      if (i == 10) chk("ovr_pulse", int'(overrun), 1);
      if (i == 11) chk("ovr_single", int'(overrun), 0);
    end
    chk("ovr_count", ovr_count - ovr_before, 1);
    chk("b2b_a_pv", int'(peak_valid), 1);
    chk("b2b_a_peak", int'(peak), 200);
    chk("b2b_a_idx", int'(peak_idx), 20);
    chk("b2b_gap_busy", int'(busy), 0);
    open_window();
    chk("b2b_busy_again", int'(busy), 1);
    for (int i = 0; i < 64; i++) send((i == 63) ? 16'h7777 : 16'h0003);
    chk("b2b_b_peak", int'(peak), 'h7777);
    chk("b2b_b_idx", int'(peak_idx), 63);
    tick();

    // Asynchronous reset mid-window
    pv_before = pv_count;
    open_window();
    for (int i = 0; i < 30; i++) send(16'h4000);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_peak", int'(peak), 0);
    chk("rst_idx", int'(peak_idx), 0);
    chk("rst_pv", int'(peak_valid), 0);
    chk("rst_ovr", int'(overrun), 0);
    tick();
    #2;
    reset = 1'b0;
    tick();
    chk("rst_no_pv", pv_count - pv_before, 0);
    open_window();
    for (int i = 0; i < 64; i++) send(16'h0001);
    chk("rst_next_peak", int'(peak), 1);
    chk("rst_next_idx", int'(peak_idx), 0);
    tick();

    // Hold in IDLE under valid data
    pv_before  = pv_count;
    ovr_before = ovr_count;
    for (int i = 0; i < 100; i++) send(WIDTH'(16'hFFFF - i));
    chk("hold_peak", int'(peak), 1);
    chk("hold_idx", int'(peak_idx), 0);
    chk("hold_busy", int'(busy), 0);
    chk("hold_no_pv", pv_count - pv_before, 0);
    chk("hold_no_ovr", ovr_count - ovr_before, 0);

    tick();
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
